// File: rtl/sa_pkg.sv
// Shared definitions for the system-agent memory executor: entry field layout,
// transaction type encoding and the executor state type.
package sa_pkg;

    // Queue entry field widths
    localparam int unsigned SA_OWNER_W = 4;
    localparam int unsigned SA_TXID_W  = 4;
    localparam int unsigned SA_DATA_W  = 32;
    localparam int unsigned SA_ADDR_W  = 16;
    localparam int unsigned SA_ENTRY_W = 57;

    // Queue entry field LSB offsets
    localparam int unsigned SA_OWNER_LSB = 0;
    localparam int unsigned SA_TXID_LSB  = 4;
    localparam int unsigned SA_TYPE_LSB  = 8;
    localparam int unsigned SA_DATA_LSB  = 9;
    localparam int unsigned SA_ADDR_LSB  = 41;

    // Transaction type encoding (entry bit SA_TYPE_LSB)
    localparam logic TX_READ  = 1'b0;
    localparam logic TX_WRITE = 1'b1;

    // Executor state
    typedef enum logic [1:0] {
        EX_IDLE,
        EX_SETUP,
        EX_ACCESS,
        EX_RESP
    } sa_exec_state_e;

endpackage

// File: rtl/sa_perf_counters.sv
// Saturating performance counters for the memory executor: completed reads,
// completed writes, and cycles spent busy. Only instantiated when
// SA_EXEC_PERF_CNT_EN is defined.
module sa_perf_counters (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rd_done,
    input  logic        wr_done,
    input  logic        busy,
    output logic [15:0] perf_rd_cnt,
    output logic [15:0] perf_wr_cnt,
    output logic [31:0] perf_busy_cyc
);

    // Count completions by type and busy cycles; each counter sticks at all-ones
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_rd_cnt   <= '0;
            perf_wr_cnt   <= '0;
            perf_busy_cyc <= '0;
        end else begin
            if (rd_done && (perf_rd_cnt != '1))
                perf_rd_cnt <= perf_rd_cnt + 16'd1;
            if (wr_done && (perf_wr_cnt != '1))
                perf_wr_cnt <= perf_wr_cnt + 16'd1;
            if (busy && (perf_busy_cyc != '1))
                perf_busy_cyc <= perf_busy_cyc + 32'd1;
        end
    end

endmodule

// File: rtl/sa_mem_executor.sv
// System-agent memory executor: pops the head of the transaction queue, runs
// it on the single-port memory bus (SETUP -> ACCESS x N -> RESP) and returns
// a one-cycle completion to the owning IP. One transaction in flight.
// Optional: define SA_EXEC_PERF_CNT_EN to add read/write/busy-cycle counters.
module sa_mem_executor
    import sa_pkg::*;
#(
    parameter int unsigned RD_WAIT = 2,
    parameter int unsigned WR_HOLD = 1,
    parameter int unsigned ENTRY_W = 57
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               q_valid,
    input  logic [ENTRY_W-1:0] q_entry,
    output logic               q_pop,
    output logic               mem_cs,
    output logic               mem_we,
    output logic [15:0]        mem_addr,
    output logic [31:0]        mem_wdata,
    output logic               mem_oe,
    input  logic [31:0]        mem_rdata,
    output logic               cpl_valid,
    output logic [3:0]         cpl_owner,
    output logic [3:0]         cpl_id,
    output logic               cpl_we,
    output logic [31:0]        cpl_rdata,
    output logic               busy
`ifdef SA_EXEC_PERF_CNT_EN
    ,
    output logic [15:0]        perf_rd_cnt,
    output logic [15:0]        perf_wr_cnt,
    output logic [31:0]        perf_busy_cyc
`endif
);

    if ((RD_WAIT < 1) || (RD_WAIT > 15)) begin : g_bad_rd_wait
        $error("sa_mem_executor: RD_WAIT must be in 1..15");
    end
    if ((WR_HOLD < 1) || (WR_HOLD > 15)) begin : g_bad_wr_hold
        $error("sa_mem_executor: WR_HOLD must be in 1..15");
    end
    if (ENTRY_W != SA_ENTRY_W) begin : g_bad_entry_w
        $error("sa_mem_executor: ENTRY_W must equal SA_ENTRY_W");
    end

    sa_exec_state_e        state;
    logic [3:0]            wait_cnt;
    logic [SA_OWNER_W-1:0] lat_owner;
    logic [SA_TXID_W-1:0]  lat_id;
    logic                  lat_we;

    // Head is consumed in the same cycle it is seen while idle; never during reset
    always_comb begin
        q_pop = rst_n && (state == EX_IDLE) && q_valid;
    end

    // Executor FSM; all bus and completion outputs are registered here
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= EX_IDLE;
            wait_cnt  <= '0;
            lat_owner <= '0;
            lat_id    <= '0;
            lat_we    <= 1'b0;
            mem_cs    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_oe    <= 1'b0;
            cpl_valid <= 1'b0;
            cpl_owner <= '0;
            cpl_id    <= '0;
            cpl_we    <= 1'b0;
            cpl_rdata <= '0;
            busy      <= 1'b0;
        end else begin
            cpl_valid <= 1'b0;
            case (state)
                EX_IDLE: begin
                    if (q_valid) begin
                        // Bus address/direction are set up straight from the
                        // popped entry so they are valid throughout SETUP.
                        lat_owner <= q_entry[SA_OWNER_LSB +: SA_OWNER_W];
                        lat_id    <= q_entry[SA_TXID_LSB +: SA_TXID_W];
                        lat_we    <= q_entry[SA_TYPE_LSB];
                        mem_addr  <= q_entry[SA_ADDR_LSB +: SA_ADDR_W];
                        mem_we    <= (q_entry[SA_TYPE_LSB] == TX_WRITE);
                        mem_oe    <= (q_entry[SA_TYPE_LSB] == TX_WRITE);
                        if (q_entry[SA_TYPE_LSB] == TX_WRITE)
                            mem_wdata <= q_entry[SA_DATA_LSB +: SA_DATA_W];
                        busy  <= 1'b1;
                        state <= EX_SETUP;
                    end
                end
                EX_SETUP: begin
                    wait_cnt <= lat_we ? 4'(WR_HOLD) : 4'(RD_WAIT);
                    mem_cs   <= 1'b1;
                    state    <= EX_ACCESS;
                end
                EX_ACCESS: begin
                    wait_cnt <= wait_cnt - 4'd1;
                    if (wait_cnt == 4'd1) begin
                        mem_cs    <= 1'b0;
                        mem_oe    <= 1'b0;
                        mem_we    <= 1'b0;
                        cpl_valid <= 1'b1;
                        cpl_owner <= lat_owner;
                        cpl_id    <= lat_id;
                        cpl_we    <= lat_we;
                        cpl_rdata <= lat_we ? '0 : mem_rdata;
                        state     <= EX_RESP;
                    end
                end
                EX_RESP: begin
                    busy  <= 1'b0;
                    state <= EX_IDLE;
                end
                default: begin
                    state <= EX_IDLE;
                end
            endcase
        end
    end

`ifdef SA_EXEC_PERF_CNT_EN
    sa_perf_counters u_perf (
        .clk          (clk),
        .rst_n        (rst_n),
        .rd_done      (cpl_valid && !cpl_we),
        .wr_done      (cpl_valid && cpl_we),
        .busy         (busy),
        .perf_rd_cnt  (perf_rd_cnt),
        .perf_wr_cnt  (perf_wr_cnt),
        .perf_busy_cyc(perf_busy_cyc)
    );
`endif

endmodule

// File: tb/tb_sa_mem_executor.sv
// Self-checking bench for sa_mem_executor (RD_WAIT=2, WR_HOLD=1).
module tb_sa_mem_executor;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        q_valid;
    logic [56:0] q_entry;
    logic        q_pop;
    logic        mem_cs, mem_we, mem_oe;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        cpl_valid, cpl_we, busy;
    logic [3:0]  cpl_owner, cpl_id;
    logic [31:0] cpl_rdata;
`ifdef SA_EXEC_PERF_CNT_EN
    logic [15:0] perf_rd_cnt, perf_wr_cnt;
    logic [31:0] perf_busy_cyc;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sa_mem_executor #(
        .RD_WAIT(2),
        .WR_HOLD(1),
        .ENTRY_W(57)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .q_valid  (q_valid),
        .q_entry  (q_entry),
        .q_pop    (q_pop),
        .mem_cs   (mem_cs),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_oe   (mem_oe),
        .mem_rdata(mem_rdata),
        .cpl_valid(cpl_valid),
        .cpl_owner(cpl_owner),
        .cpl_id   (cpl_id),
        .cpl_we   (cpl_we),
        .cpl_rdata(cpl_rdata),
        .busy     (busy)
`ifdef SA_EXEC_PERF_CNT_EN
        ,
        .perf_rd_cnt  (perf_rd_cnt),
        .perf_wr_cnt  (perf_wr_cnt),
        .perf_busy_cyc(perf_busy_cyc)
`endif
    );

    typedef struct {
        logic        qv;
        logic [56:0] entry;
        logic [31:0] rdata;
        logic        e_pop;
        logic        e_cs;
        logic        e_we;
        logic        e_oe;
        logic [15:0] e_addr;
        logic [31:0] e_wdata;
        logic        e_cplv;
        logic [3:0]  e_owner;
        logic [3:0]  e_id;
        logic        e_cwe;
        logic [31:0] e_crdata;
        logic        e_busy;
    } vec_t;

    function automatic logic [56:0] mk(input logic [3:0] owner, input logic [3:0] id,
                                       input logic wr, input logic [31:0] data,
                                       input logic [15:0] addr);
        return {addr, data, wr, id, owner};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Issue one entry on an idle executor and wait for its completion
    task automatic do_txn(input logic [56:0] e, input logic [3:0] exp_id);
        bit got;
        @(posedge clk); #1;
        q_valid = 1'b1;
        q_entry = e;
        @(negedge clk);
        chk("txn_pop", 64'(q_pop), 64'd1);
        @(posedge clk); #1;
        q_valid = 1'b0;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (cpl_valid) got = 1;
        end
        chk("txn_cpl_seen", 64'(got), 64'd1);
        chk("txn_cpl_id", 64'(cpl_id), 64'(exp_id));
        got = 0;
        for (int i = 0; i < 5 && !got; i++) begin
            @(negedge clk);
            if (!busy) got = 1;
        end
        chk("txn_idle", 64'(got), 64'd1);
    endtask

    vec_t tv[10];

    initial begin
        logic [56:0] rd_e, wr_e;
        int lp, npop, ncpl;
        bit pend, got;

        rd_e = mk(4'd2, 4'd5, 1'b0, 32'h0, 16'h1234);
        wr_e = mk(4'd7, 4'd3, 1'b1, 32'hCAFEF00D, 16'h00FF);
        //           qv    entry  rdata          pop   cs    we    oe    addr      wdata          cplv  own   id    cwe   crdata         busy
        tv[0] = '{1'b1, rd_e,  32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 32'h0,         1'b0, 4'd0, 4'd0, 1'b0, 32'h0,         1'b0};
        tv[1] = '{1'b0, rd_e,  32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 16'h1234, 32'h0,         1'b0, 4'd0, 4'd0, 1'b0, 32'h0,         1'b1};
        tv[2] = '{1'b0, 57'h0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 16'h1234, 32'h0,         1'b0, 4'd0, 4'd0, 1'b0, 32'h0,         1'b1};
        tv[3] = '{1'b0, 57'h0, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0, 1'b0, 16'h1234, 32'h0,         1'b0, 4'd0, 4'd0, 1'b0, 32'h0,         1'b1};
        tv[4] = '{1'b0, 57'h0, 32'h12345678, 1'b0, 1'b0, 1'b0, 1'b0, 16'h1234, 32'h0,         1'b1, 4'd2, 4'd5, 1'b0, 32'hDEADBEEF,  1'b1};
        tv[5] = '{1'b1, wr_e,  32'h12345678, 1'b1, 1'b0, 1'b0, 1'b0, 16'h1234, 32'h0,         1'b0, 4'd2, 4'd5, 1'b0, 32'hDEADBEEF,  1'b0};
        tv[6] = '{1'b0, wr_e,  32'h12345678, 1'b0, 1'b0, 1'b1, 1'b1, 16'h00FF, 32'hCAFEF00D,  1'b0, 4'd2, 4'd5, 1'b0, 32'hDEADBEEF,  1'b1};
        tv[7] = '{1'b0, 57'h0, 32'h12345678, 1'b0, 1'b1, 1'b1, 1'b1, 16'h00FF, 32'hCAFEF00D,  1'b0, 4'd2, 4'd5, 1'b0, 32'hDEADBEEF,  1'b1};
        tv[8] = '{1'b0, 57'h0, 32'h12345678, 1'b0, 1'b0, 1'b0, 1'b0, 16'h00FF, 32'hCAFEF00D,  1'b1, 4'd7, 4'd3, 1'b1, 32'h0,         1'b1};
        tv[9] = '{1'b0, 57'h0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 16'h00FF, 32'hCAFEF00D,  1'b0, 4'd7, 4'd3, 1'b1, 32'h0,         1'b0};

        rst_n     = 1'b0;
        q_valid   = 1'b0;
        q_entry   = '0;
        mem_rdata = '0;
        #12;
        chk("rst_pop", 64'(q_pop), 64'd0);
        chk("rst_cs", 64'(mem_cs), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_cplv", 64'(cpl_valid), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single read then single write, cycle by cycle
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            q_valid   = tv[k].qv;
            q_entry   = tv[k].entry;
            mem_rdata = tv[k].rdata;
            @(negedge clk);
            chk($sformatf("v%0d_pop", k), 64'(q_pop), 64'(tv[k].e_pop));
            chk($sformatf("v%0d_cs", k), 64'(mem_cs), 64'(tv[k].e_cs));
            chk($sformatf("v%0d_we", k), 64'(mem_we), 64'(tv[k].e_we));
            chk($sformatf("v%0d_oe", k), 64'(mem_oe), 64'(tv[k].e_oe));
            chk($sformatf("v%0d_addr", k), 64'(mem_addr), 64'(tv[k].e_addr));
            chk($sformatf("v%0d_wdata", k), 64'(mem_wdata), 64'(tv[k].e_wdata));
            chk($sformatf("v%0d_cplv", k), 64'(cpl_valid), 64'(tv[k].e_cplv));
            chk($sformatf("v%0d_owner", k), 64'(cpl_owner), 64'(tv[k].e_owner));
            chk($sformatf("v%0d_id", k), 64'(cpl_id), 64'(tv[k].e_id));
            chk($sformatf("v%0d_cwe", k), 64'(cpl_we), 64'(tv[k].e_cwe));
            chk($sformatf("v%0d_crdata", k), 64'(cpl_rdata), 64'(tv[k].e_crdata));
            chk($sformatf("v%0d_busy", k), 64'(busy), 64'(tv[k].e_busy));
        end

        // Back-to-back reads ids 1,2,3 with q_valid held high
        lp = -100; npop = 0; ncpl = 0; pend = 0;
        for (int cyc = 0; cyc < 25; cyc++) begin
            @(posedge clk); #1;
            mem_rdata = 32'hA000_0000 + 32'(cyc);
            if (cyc == 0) begin
                q_valid = 1'b1;
                q_entry = mk(4'd1, 4'd1, 1'b0, 32'h0, 16'h0100);
            end else if (pend) begin
                pend = 0;
                if (npop == 3) q_valid = 1'b0;
                else q_entry = mk(4'd1, 4'(npop + 1), 1'b0, 32'h0, 16'(16'h0100 + npop));
            end
            @(negedge clk);
            chk($sformatf("b2b_cs_c%0d", cyc), 64'(mem_cs), 64'((cyc - lp == 2) || (cyc - lp == 3)));
            if (cpl_valid) begin
                chk("b2b_cpl_id", 64'(cpl_id), 64'(ncpl + 1));
                chk("b2b_cpl_lat", 64'(cyc - lp), 64'd4);
                chk("b2b_cpl_rdata", 64'(cpl_rdata), 64'(32'hA000_0000 + 32'(cyc - 1)));
                ncpl++;
            end
            if (q_pop) begin
                if (npop > 0) chk("b2b_pop_gap", 64'(cyc - lp), 64'd5);
                lp = cyc;
                npop++;
                pend = 1;
            end
        end
        chk("b2b_npop", 64'(npop), 64'd3);
        chk("b2b_ncpl", 64'(ncpl), 64'd3);

        // Reset asserted during ACCESS of a write
        @(posedge clk); #1;
        q_valid = 1'b1;
        q_entry = mk(4'd1, 4'hA, 1'b1, 32'h0000_55AA, 16'h0042);
        mem_rdata = 32'h0BAD_F00D;
        @(negedge clk);
        chk("rst4_pop", 64'(q_pop), 64'd1);
        @(posedge clk); #1;
        q_valid = 1'b0;
        @(negedge clk);
        chk("rst4_setup_oe", 64'(mem_oe), 64'd1);
        chk("rst4_setup_cs", 64'(mem_cs), 64'd0);
        @(negedge clk);
        chk("rst4_access_cs", 64'(mem_cs), 64'd1);
        #1;
        rst_n   = 1'b0;
        q_valid = 1'b1;
        q_entry = mk(4'd3, 4'd9, 1'b0, 32'h0, 16'h0777);
        #1;
        chk("rst4_cs_drop", 64'(mem_cs), 64'd0);
        chk("rst4_oe_drop", 64'(mem_oe), 64'd0);
        chk("rst4_we_drop", 64'(mem_we), 64'd0);
        chk("rst4_busy_drop", 64'(busy), 64'd0);
        chk("rst4_pop_forced", 64'(q_pop), 64'd0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("rst4_no_cpl", 64'(cpl_valid), 64'd0);
        end
        #1;
        rst_n = 1'b1;
        #1;
        chk("rst4_pop_after", 64'(q_pop), 64'd1);
        @(posedge clk); #1;
        q_valid = 1'b0;
        got = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            if (cpl_valid) got = 1;
        end
        chk("rst4_cpl_seen", 64'(got), 64'd1);
        chk("rst4_cpl_id", 64'(cpl_id), 64'd9);
        chk("rst4_cpl_owner", 64'(cpl_owner), 64'd3);
        chk("rst4_cpl_rdata", 64'(cpl_rdata), 64'h0BAD_F00D);
        @(negedge clk);

        // Idle for 20 cycles, then a read is accepted immediately
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk("idle_pop", 64'(q_pop), 64'd0);
            chk("idle_cs", 64'(mem_cs), 64'd0);
            chk("idle_busy", 64'(busy), 64'd0);
        end
        do_txn(mk(4'd6, 4'd4, 1'b0, 32'h0, 16'h0020), 4'd4);

`ifdef SA_EXEC_PERF_CNT_EN
        // Counters over 3 reads + 2 writes from a clean reset
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        chk("perf_rd_rst", 64'(perf_rd_cnt), 64'd0);
        chk("perf_busy_rst", 64'(perf_busy_cyc), 64'd0);
        do_txn(mk(4'd1, 4'd1, 1'b0, 32'h0, 16'h0001), 4'd1);
        do_txn(mk(4'd1, 4'd2, 1'b1, 32'h1111, 16'h0002), 4'd2);
        do_txn(mk(4'd1, 4'd3, 1'b0, 32'h0, 16'h0003), 4'd3);
        do_txn(mk(4'd1, 4'd4, 1'b1, 32'h2222, 16'h0004), 4'd4);
        do_txn(mk(4'd1, 4'd5, 1'b0, 32'h0, 16'h0005), 4'd5);
        chk("perf_rd_cnt", 64'(perf_rd_cnt), 64'd3);
        chk("perf_wr_cnt", 64'(perf_wr_cnt), 64'd2);
        chk("perf_busy_cyc", 64'(perf_busy_cyc), 64'd18);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sa_mem_executor.md
Name: sa_mem_executor

Overview:
Downstream stage of the system agent's transaction queue. Pops the head entry of the shift-register queue and executes it on the single-port memory bus (cs/we/addr/data). Returns a completion (owner, transaction ID, read data) to the requesting IP block. One transaction in flight at a time. No backpressure on completions: IPs must accept the result in the cycle it is presented.

Parameters:
RD_WAIT, 2, ACCESS cycles for a read (cs high); legal 1..15; mem_rdata sampled on the last ACCESS edge
WR_HOLD, 1, ACCESS cycles for a write (cs high); legal 1..15
ENTRY_W, 57, queue entry width; must equal the package constant

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
q_valid  in  1  queue head holds a valid entry
q_entry  in  57  head entry: [3:0] owner, [7:4] tx id, [8] type (1=write), [40:9] data, [56:41] addr
q_pop  out  1  one-cycle pulse; head consumed this edge
mem_cs  out  1  memory chip select
mem_we  out  1  memory write enable
mem_addr  out  16  memory address
mem_wdata  out  32  write data to top-level tristate
mem_oe  out  1  drive enable for shared data bus (top-level tristate)
mem_rdata  in  32  data bus sampled value
cpl_valid  out  1  one-cycle completion pulse
cpl_owner  out  4  owner field of completed entry
cpl_id  out  4  tx id of completed entry
cpl_we  out  1  completed transaction was a write
cpl_rdata  out  32  read data; 0 for write completions
busy  out  1  state != IDLE

Behaviour:
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE: if q_valid=1, then q_pop=1 (Mealy, same cycle), latch q_entry into internal regs, and go to SETUP. Otherwise remain in IDLE with q_pop=0.
- SETUP (1 cycle): mem_addr and mem_we from latched entry, mem_cs=0; for writes mem_oe=1 and mem_wdata=latched data. Load wait counter with RD_WAIT or WR_HOLD.
- ACCESS: mem_cs=1, addr/we/oe/wdata held. Counter decrements each cycle. On the cycle counter==1: a read captures mem_rdata into cpl_rdata; then go to RESP.
- RESP (1 cycle): cpl_valid=1 with owner/id/we; mem_cs=0, mem_oe=0, mem_we=0; go to IDLE.
- Latency, pop at cycle T: read cpl_valid at T+2+RD_WAIT; write cpl_valid at T+2+WR_HOLD. Back-to-back entries are popped every N+3 cycles, in queue order.
- mem_oe is high only in SETUP/ACCESS of writes; never high during reads (bus contention rule).
- All outputs except q_pop are driven from registers. q_pop is forced to 0 while rst_n=0.
- cpl_owner/cpl_id/cpl_we/cpl_rdata hold their last values between pulses. cpl_rdata is written to 0 on write completions.
- Reset (async, any state): state=IDLE; all outputs 0; counter 0. An in-flight transaction is discarded (already popped) and produces no completion. After release, normal IDLE behaviour resumes on the first clock.
- q_valid dropping mid-transaction has no effect; the entry is already latched.
- Parameter values outside 1..15 are an elaboration error.

Optional Feature:
Macro SA_EXEC_PERF_CNT_EN.
- Defined: adds output ports perf_rd_cnt[15:0] and perf_wr_cnt[15:0] (incremented on each RESP by type) and perf_busy_cyc[31:0] (incremented each cycle busy=1). All saturate at max, reset to 0.
- Undefined: ports and logic absent; core behaviour identical.

Decomposition:
- Package sa_pkg holds:
  - field widths SA_OWNER_W=4, SA_TXID_W=4, SA_DATA_W=32, SA_ADDR_W=16, SA_ENTRY_W=57
  - field LSB offsets 0/4/8/9/41
  - TX_READ=0, TX_WRITE=1
  - the executor state enum
- Sub-module sa_perf_counters holds the saturating counters; instantiated only under SA_EXEC_PERF_CNT_EN.

Test Plan:
1. Read, RD_WAIT=2: owner=2, id=5, type=0, addr=0x1234, mem_rdata=0xDEADBEEF, pop at T -> cs high T+2..T+3, addr=0x1234, we=0, oe=0; cpl_valid at T+4 with owner=2, id=5, cpl_we=0, rdata=0xDEADBEEF.
2. Write, WR_HOLD=1: type=1, data=0xCAFEF00D, addr=0x00FF -> oe=1 and we=1 at T+1..T+2, cs=1 at T+2, wdata=0xCAFEF00D; cpl_valid at T+3 with cpl_we=1, rdata=0.
3. q_valid held high with ids 1,2,3 (reads, RD_WAIT=2) -> q_pop every 5 cycles; completions with ids 1,2,3 in order; cs never high in SETUP/RESP.
4. rst_n low during ACCESS of a write -> cs/oe/we drop immediately with no clock edge; no cpl_valid; the next entry after release completes normally.
5. q_valid=0 for 20 cycles -> q_pop=0, cs=0, busy=0; then a read is accepted on the first cycle q_valid=1.
6. With SA_EXEC_PERF_CNT_EN: 3 reads + 2 writes (RD_WAIT=2, WR_HOLD=1) -> perf_rd_cnt=3, perf_wr_cnt=2, perf_busy_cyc=3*4+2*3=18.
